// File: rtl/traffic_light_pkg.sv
// Shared light codes, phase/FSM encodings and code helpers for the traffic light monitor.
package traffic_light_pkg;

  localparam logic [2:0] CODE_MG = 3'b001;
  localparam logic [2:0] CODE_MY = 3'b010;
  localparam logic [2:0] CODE_CG = 3'b100;
  localparam logic [2:0] CODE_CY = 3'b110;

  localparam logic [7:0] GREEN_DEFAULT  = 8'd5;
  localparam logic [7:0] YELLOW_DEFAULT = 8'd3;

  typedef enum logic [1:0] {
    PH_MG = 2'd0,
    PH_MY = 2'd1,
    PH_CG = 2'd2,
    PH_CY = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ST_NO_REF,
    ST_SYNC,
    ST_LOCKED
  } fsm_state_t;

  function automatic logic code_legal(input logic [2:0] code);
    return (code == CODE_MG) || (code == CODE_MY) || (code == CODE_CG) || (code == CODE_CY);
  endfunction

  function automatic phase_t code_phase(input logic [2:0] code);
    case (code)
      CODE_MY: return PH_MY;
      CODE_CG: return PH_CG;
      CODE_CY: return PH_CY;
      default: return PH_MG;
    endcase
  endfunction

  function automatic logic [2:0] successor(input logic [2:0] code);
    case (code)
      CODE_MG: return CODE_MY;
      CODE_MY: return CODE_CG;
      CODE_CG: return CODE_CY;
      default: return CODE_MG;
    endcase
  endfunction

  function automatic logic needs_green(input logic [2:0] code);
    return (code == CODE_MG) || (code == CODE_CG);
  endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// 8-bit dwell counter: load restarts at 1, increment saturates at 255.
module tl_dwell_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= 8'd1;
    end else if (inc && (count != '1)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Observes a traffic light code stream, checks successor order and phase dwell,
// and reports registered error pulses plus cycle/error statistics.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter logic [7:0] GREEN_CYCLES  = GREEN_DEFAULT,
  parameter logic [7:0] YELLOW_CYCLES = YELLOW_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_in,
  input  logic       clear,
  output logic [1:0] phase,
  output logic       locked,
  output logic       err_code,
  output logic       err_seq,
  output logic       err_dwell,
  output logic       err_any,
  output logic [7:0] cycle_count,
  output logic [7:0] err_count
);

  fsm_state_t state;
  fsm_state_t next_state;
  logic [2:0] prev_code;
  logic [2:0] next_prev;
  logic [7:0] dwell;
  logic [7:0] required;
  logic       dwell_load;
  logic       dwell_inc;
  logic       fire_code;
  logic       fire_seq;
  logic       fire_dwell;
  logic       cycle_done;
  logic       any_err;

  tl_dwell_counter u_dwell (
    .clk   (clk),
    .reset (reset),
    .load  (dwell_load),
    .inc   (dwell_inc),
    .count (dwell)
  );

  always_comb begin
    required   = needs_green(prev_code) ? GREEN_CYCLES : YELLOW_CYCLES;
    next_state = state;
    next_prev  = prev_code;
    dwell_load = 1'b0;
    dwell_inc  = 1'b0;
    fire_code  = 1'b0;
    fire_seq   = 1'b0;
    fire_dwell = 1'b0;
    cycle_done = 1'b0;
    if (!code_legal(light_in)) begin
      fire_code  = 1'b1;
      next_state = ST_NO_REF;
    end else begin
      case (state)
        ST_NO_REF: begin
          next_prev  = light_in;
          dwell_load = 1'b1;
          next_state = ST_SYNC;
        end
        ST_SYNC: begin
          if (light_in == prev_code) begin
            dwell_inc = 1'b1;
          end else begin
            next_prev  = light_in;
            dwell_load = 1'b1;
            if (light_in == successor(prev_code)) next_state = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (light_in == prev_code) begin
            // Overrun is judged on the count before this sample is added.
            dwell_inc = 1'b1;
            if (dwell == required) begin
              fire_dwell = 1'b1;
              next_state = ST_SYNC;
            end
          end else begin
            next_prev  = light_in;
            dwell_load = 1'b1;
            if (light_in != successor(prev_code)) begin
              fire_seq   = 1'b1;
              next_state = ST_SYNC;
            end else if (dwell < required) begin
              fire_dwell = 1'b1;
              next_state = ST_SYNC;
            end else begin
              cycle_done = (prev_code == CODE_CY);
            end
          end
        end
        default: next_state = ST_NO_REF;
      endcase
    end
    any_err = fire_code | fire_seq | fire_dwell;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_NO_REF;
      prev_code   <= CODE_MG;
      phase       <= '0;
      locked      <= 1'b0;
      err_code    <= 1'b0;
      err_seq     <= 1'b0;
      err_dwell   <= 1'b0;
      err_any     <= 1'b0;
      cycle_count <= '0;
      err_count   <= '0;
    end else begin
      state     <= next_state;
      prev_code <= next_prev;
      locked    <= (next_state == ST_LOCKED);
      err_code  <= fire_code;
      err_seq   <= fire_seq;
      err_dwell <= fire_dwell;
      if (code_legal(light_in)) phase <= code_phase(light_in);
      if (clear) begin
        cycle_count <= '0;
        err_count   <= '0;
        err_any     <= 1'b0;
      end else begin
        if (cycle_done) cycle_count <= cycle_count + 8'd1;
        if (any_err) begin
          err_any <= 1'b1;
          if (err_count != '1) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule
